darkquad_timekeeper_core: RTL
=============================

// Module: darkquad_timekeeper_core
// PURPOSE
//  Produces sec_now (32b seconds) and sub_sec (cycles into current second); sec_now feeds the simulink2ppc OPB register.
//  Free-runs from user_clk; locks to external 1PPS and flywheels through missing pulses.
//  Software presets the seconds value through a ppc2simulink register pair (sec_set/sec_load).
// PARAMETERS
//  CLK_HZ    250000000  user_clk cycles per nominal second
//  TOL       1000       accepted PPS interval deviation, cycles (+/-)
//  LOCK_CNT  3          consecutive good PPS intervals needed to lock
//  CNT_W     28         width of sub_sec / interval counters; must hold CLK_HZ+TOL
// PORTS
//  user_clk     in   1      fabric clock; all logic rising-edge
//  user_rst_n   in   1      asynchronous active-low reset
//  pps_in       in   1      external 1PPS, asynchronous to user_clk
//  sec_set      in   32     seconds value to load (software register)
//  sec_load     in   1      level from software; rising edge arms a load
//  sec_now      out  32     current seconds count
//  sub_sec      out  CNT_W  cycles since last second boundary
//  sec_strobe   out  1      1-cycle pulse, high in first cycle of each new second
//  pps_locked   out  1      1 = boundaries taken from PPS
//  load_pend    out  1      load armed, not yet applied
//  pps_err_cnt  out  16     saturating count of PPS faults (glitch or loss of lock)
// BEHAVIOUR
//  Reset: all outputs 0, state UNLOCKED, good_cnt=0, pps_ivl=all-ones (saturated), sync flops 0.
//  PPS path: 2-flop sync + registered rising-edge detect -> pps_rise; 1 cycle wide.
//  pps_ivl: +1 per cycle, saturates at all-ones; cleared to 0 on pps_rise.
//   good edge: pps_rise and (pps_ivl+1) in [CLK_HZ-TOL, CLK_HZ+TOL].
//  Boundary: sub_sec<=0; sec_now<=load_pend?sec_set:sec_now+1 (32b wrap 0xFFFFFFFF->0);
//   load_pend<=0; sec_strobe=1 next cycle. Otherwise sub_sec<=sub_sec+1.
//  UNLOCKED:
//   - Boundary when sub_sec==CLK_HZ-1; PPS does not move timing.
//   - good edge: good_cnt+1; bad edge: good_cnt<=0.
//   - Edge making good_cnt==LOCK_CNT -> LOCKED, good_cnt<=0, phase-align boundary on that cycle.
//   - Align: sec_now advances only if sub_sec>=CLK_HZ/2, else held (sub_sec still 0).
//   - Internal rollover on same cycle as lock edge: single boundary, sec_now+1 once.
//  LOCKED:
//   - pps_rise with sub_sec>=CLK_HZ-TOL-1 -> boundary.
//   - Earlier pps_rise -> ignored (no boundary), pps_err_cnt+1.
//   - sub_sec==CLK_HZ+TOL-1 without PPS -> flywheel boundary, UNLOCKED, pps_err_cnt+1.
//  Latency: pps_in rise sampled at clk edge n -> sec_now/sub_sec/sec_strobe new values after edge n+3.
//  Load: sec_load 0->1 (registered compare, same clock domain) sets load_pend.
//   Arm on the boundary cycle itself: applied at that boundary. Further edges while pending: no effect.
//   sec_set sampled at the boundary, not at arm time.
//  pps_err_cnt saturates at 0xFFFF; cleared only by reset.
//  Reset mid-second: immediate async return to reset values; count restarts at sec_now=0, sub_sec=0.
// TESTING  (CLK_HZ=100, TOL=2, LOCK_CNT=3, CNT_W=8)
//  1 reset, no PPS -> sec_strobe every 100 cycles, sec_now 0,1,2..; sub_sec 0..99; pps_locked=0.
//  2 PPS every 100 cycles -> pps_locked=1 on 4th pulse (3 good intervals);
//    then strobe 3 clks after each pps_in rise, sub_sec tops at 99.
//  3 PPS period 97 (outside +/-2) -> never locks; timing free-runs at 100; pps_err_cnt=0.
//  4 locked, PPS stopped -> flywheel strobe at sub_sec=101; pps_locked=0; pps_err_cnt=1;
//    next period 100.
//  5 locked, extra 1-cycle pps_in at sub_sec=40 -> no strobe, sec_now unchanged, pps_err_cnt+1, still locked.
//  6 sec_set=0x5A000000, sec_load pulse at sub_sec=30 -> load_pend=1;
//    next boundary sec_now=0x5A000000, load_pend=0; then 0x5A000001.
//    Also sec_now=0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/darkquad_timekeeper_core.sv
// -----------------------------------------------------------------------------
// darkquad_timekeeper_core
//
// Seconds/sub-second timekeeper. It free-runs from user_clk, locks its second
// boundaries to an external 1PPS once enough consecutive good PPS intervals
// have been seen, and flywheels through missing pulses. Software can preset
// the seconds count; the preset takes effect at the next second boundary.
//
// Ports
//   user_clk     in   fabric clock, all logic on the rising edge
//   user_rst_n   in   asynchronous active-low reset
//   pps_in       in   external 1PPS, asynchronous to user_clk
//   sec_set      in   [31:0] seconds value to load
//   sec_load     in   level from software; a rising edge arms a load
//   sec_now      out  [31:0] current seconds count
//   sub_sec      out  [CNT_W-1:0] cycles since the last second boundary
//   sec_strobe   out  one-cycle pulse in the first cycle of each new second
//   pps_locked   out  1 = second boundaries are taken from PPS
//   load_pend    out  load armed but not yet applied
//   pps_err_cnt  out  [15:0] saturating count of PPS glitches / lock losses
// -----------------------------------------------------------------------------
module darkquad_timekeeper_core #(
  parameter int unsigned CLK_HZ   = 250000000,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned CNT_W    = 28
) (
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic             pps_in,
  input  logic [31:0]      sec_set,
  input  logic             sec_load,
  output logic [31:0]      sec_now,
  output logic [CNT_W-1:0] sub_sec,
  output logic             sec_strobe,
  output logic             pps_locked,
  output logic             load_pend,
  output logic [15:0]      pps_err_cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  // sub_sec thresholds
  localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(CLK_HZ - 1);         // free-run rollover
  localparam logic [CNT_W-1:0] SUB_HALF = CNT_W'(CLK_HZ / 2);         // align: advance or hold
  localparam logic [CNT_W-1:0] SUB_WIN  = CNT_W'(CLK_HZ - TOL - 1);   // earliest accepted PPS
  localparam logic [CNT_W-1:0] SUB_FLY  = CNT_W'(CLK_HZ + TOL - 1);   // flywheel deadline

  // Interval acceptance window, one bit wider so a saturated counter + 1
  // cannot wrap into the window.
  localparam logic [CNT_W:0] IVL_MIN = (CNT_W + 1)'(CLK_HZ - TOL);
  localparam logic [CNT_W:0] IVL_MAX = (CNT_W + 1)'(CLK_HZ + TOL);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;

  logic              pps_sync1_q, pps_sync2_q, pps_prev_q;
  logic              pps_rise_q, pps_rise_d;
  logic [CNT_W-1:0]  pps_ivl_q, pps_ivl_d;
  logic [CNT_W:0]    ivl_plus1;
  logic              good_edge;

  logic [CNT_W-1:0]  sub_sec_q, sub_sec_d;
  logic [31:0]       sec_now_q, sec_now_d;
  logic              sec_strobe_q, sec_strobe_d;
  logic              load_pend_q, load_pend_d;
  logic              sec_load_q;
  logic              load_rise;
  logic [15:0]       pps_err_cnt_q, pps_err_cnt_d;

  logic              boundary;   // this cycle ends the current second
  logic              advance;    // sec_now increments at this boundary
  logic              err_inc;    // a PPS fault was seen this cycle

  // ---------------------------------------------------------------------------
  // State register and all other flops
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, with the async
  // reset in the sensitivity list so reset acts without a clock.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= ST_UNLOCKED;
      good_cnt_q    <= '0;
      pps_sync1_q   <= 1'b0;
      pps_sync2_q   <= 1'b0;
      pps_prev_q    <= 1'b0;
      pps_rise_q    <= 1'b0;
      pps_ivl_q     <= '1;
      sub_sec_q     <= '0;
      sec_now_q     <= '0;
      sec_strobe_q  <= 1'b0;
      load_pend_q   <= 1'b0;
      sec_load_q    <= 1'b0;
      pps_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      pps_sync1_q   <= pps_in;
      pps_sync2_q   <= pps_sync1_q;
      pps_prev_q    <= pps_sync2_q;
      pps_rise_q    <= pps_rise_d;
      pps_ivl_q     <= pps_ivl_d;
      sub_sec_q     <= sub_sec_d;
      sec_now_q     <= sec_now_d;
      sec_strobe_q  <= sec_strobe_d;
      load_pend_q   <= load_pend_d;
      sec_load_q    <= sec_load;
      pps_err_cnt_q <= pps_err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: lock tracking and boundary decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can infer a latch.
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    boundary   = 1'b0;
    advance    = 1'b1;
    err_inc    = 1'b0;

    case (state_q)
      ST_UNLOCKED: begin
        if (sub_sec_q == SUB_LAST) boundary = 1'b1;
        if (pps_rise_q) begin
          if (!good_edge) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            // Lock edge: snap the second boundary onto this PPS. Less than
            // half a second in means this PPS marks the second just begun.
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
            boundary   = 1'b1;
            advance    = (sub_sec_q >= SUB_HALF);
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        if (pps_rise_q) begin
          if (sub_sec_q >= SUB_WIN) boundary = 1'b1;
          else                      err_inc  = 1'b1;   // glitch, ignored
        end else if (sub_sec_q == SUB_FLY) begin
          boundary = 1'b1;
          err_inc  = 1'b1;
          state_d  = ST_UNLOCKED;
        end
      end

      default: state_d = ST_UNLOCKED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: PPS edge/interval, time counters, load and error count
  // ---------------------------------------------------------------------------
  always_comb begin
    pps_rise_d = pps_sync2_q & ~pps_prev_q;

    if (pps_rise_q)       pps_ivl_d = '0;
    else if (&pps_ivl_q)  pps_ivl_d = pps_ivl_q;
    else                  pps_ivl_d = pps_ivl_q + CNT_W'(1);

    ivl_plus1 = {1'b0, pps_ivl_q} + (CNT_W + 1)'(1);
    good_edge = (ivl_plus1 >= IVL_MIN) && (ivl_plus1 <= IVL_MAX);

    load_rise = sec_load & ~sec_load_q;

    sub_sec_d    = sub_sec_q + CNT_W'(1);
    sec_now_d    = sec_now_q;
    load_pend_d  = load_pend_q | load_rise;
    sec_strobe_d = boundary;

    if (boundary) begin
      sub_sec_d   = '0;
      load_pend_d = 1'b0;
      // A load armed on the boundary cycle itself is applied here too.
      if (load_pend_q || load_rise) sec_now_d = sec_set;
      else if (advance)             sec_now_d = sec_now_q + 32'd1;
    end

    pps_err_cnt_d = pps_err_cnt_q;
    if (err_inc && (pps_err_cnt_q != 16'hFFFF)) pps_err_cnt_d = pps_err_cnt_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pps_locked  = (state_q == ST_LOCKED);
    sec_now     = sec_now_q;
    sub_sec     = sub_sec_q;
    sec_strobe  = sec_strobe_q;
    load_pend   = load_pend_q;
    pps_err_cnt = pps_err_cnt_q;
  end

endmodule
